// File: rtl/mem_access_unit_if.sv
// Bus-side interface of mem_access_unit: word-aligned request/acknowledge
// memory port. The unit drives the request side (master modport); the
// memory or testbench drives read data and acknowledge (slave modport).
interface mem_access_unit_if;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [3:0]  busByteEn;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        busAck;

    modport master (
        output busReq,
        output busWe,
        output busAddr,
        output busByteEn,
        output busWData,
        input  busRData,
        input  busAck
    );

    modport slave (
        input  busReq,
        input  busWe,
        input  busAddr,
        input  busByteEn,
        input  busWData,
        output busRData,
        output busAck
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns pipeline load/store requests into single word-wide
// bus transactions (IDLE -> REQ -> DONE -> IDLE), handling byte/half lane
// placement for stores and lane extraction plus sign/zero extension for loads.
// The pipeline is held with 'stall' from the request cycle until the bus
// acknowledges.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses are rejected, no bus request is
//               issued and addrError pulses for one cycle.
//   undefined : addrError is always 0; misaligned low address bits are
//               cleared and the access proceeds as an aligned one.
//
// Access-width encodings normally come from ISA.v; local fallbacks are used
// when those macros are not already defined.
`ifndef MEM_WORD
`define MEM_WORD 2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'b01
`endif
`ifndef MEM_BYTE
`define MEM_BYTE 2'b10
`endif

module mem_access_unit (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      memRead,
    input  logic                      memWrite,
    input  logic [1:0]                mode,
    input  logic                      signExt,
    input  logic [31:0]               addr,
    input  logic [31:0]               writeData,
    output logic [31:0]               readData,
    output logic                      stall,
    output logic                      addrError,
    mem_access_unit_if.master         bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_t;

    state_t      state_r;
    logic        load_r;
    size_t       size_r;
    logic        sext_r;
    logic [1:0]  offs_r;

    size_t       size_s;
    logic        req_s;
    logic        store_s;
    logic        err_s;
    logic [1:0]  offs_s;

    // Byte enables for the access; loads always read the full word.
    function automatic logic [3:0] access_byte_en(input size_t sz,
                                                  input logic [1:0] offs,
                                                  input logic is_store);
        logic [3:0] be;
        if (!is_store) begin
            be = 4'b1111;
        end else begin
            case (sz)
                SZ_BYTE: be = 4'b0001 << offs;
                SZ_HALF: be = offs[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Store data replicated across lanes so the enabled lanes carry it.
    function automatic logic [31:0] access_wdata(input size_t sz,
                                                 input logic [31:0] wd,
                                                 input logic is_store);
        logic [31:0] d;
        if (!is_store) begin
            d = 32'h0000_0000;
        end else begin
            case (sz)
                SZ_BYTE: d = {4{wd[7:0]}};
                SZ_HALF: d = {2{wd[15:0]}};
                default: d = wd;
            endcase
        end
        return d;
    endfunction

    // Little-endian lane extraction with sign or zero extension.
    function automatic logic [31:0] format_load(input size_t sz,
                                                input logic sext,
                                                input logic [1:0] offs,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (offs)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            2'b11:   b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = offs[1] ? rdata[31:16] : rdata[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Decode request type and access width; unknown encodings act as word.
    always_comb begin
        req_s   = memRead | memWrite;
        store_s = memWrite;
        case (mode)
            `MEM_HALF: size_s = SZ_HALF;
            `MEM_BYTE: size_s = SZ_BYTE;
            default:   size_s = SZ_WORD;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Flag misaligned half/word accesses; the address is used as given.
    always_comb begin
        offs_s = addr[1:0];
        case (size_s)
            SZ_HALF: err_s = addr[0];
            SZ_WORD: err_s = (addr[1:0] != 2'b00);
            default: err_s = 1'b0;
        endcase
    end
`else
    // Without alignment checking, drop the low bits a wider access cannot use.
    always_comb begin
        err_s = 1'b0;
        case (size_s)
            SZ_HALF: offs_s = {addr[1], 1'b0};
            SZ_WORD: offs_s = 2'b00;
            default: offs_s = addr[1:0];
        endcase
    end
`endif

    // Pipeline hold: raised in the request cycle and throughout the bus wait.
    always_comb begin
        case (state_r)
            ST_IDLE: stall = req_s & ~err_s;
            ST_REQ:  stall = 1'b1;
            ST_DONE: stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Transaction FSM with registered bus outputs, load result and error flag.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r       <= ST_IDLE;
            bus.busReq    <= 1'b0;
            bus.busWe     <= 1'b0;
            bus.busAddr   <= 32'h0000_0000;
            bus.busByteEn <= 4'b0000;
            bus.busWData  <= 32'h0000_0000;
            readData      <= 32'h0000_0000;
            addrError     <= 1'b0;
            load_r        <= 1'b0;
            size_r        <= SZ_WORD;
            sext_r        <= 1'b0;
            offs_r        <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    addrError <= req_s & err_s;
                    if (req_s && !err_s) begin
                        state_r       <= ST_REQ;
                        bus.busReq    <= 1'b1;
                        bus.busWe     <= store_s;
                        bus.busAddr   <= {addr[31:2], 2'b00};
                        bus.busByteEn <= access_byte_en(size_s, offs_s, store_s);
                        bus.busWData  <= access_wdata(size_s, writeData, store_s);
                        load_r        <= ~store_s;
                        size_r        <= size_s;
                        sext_r        <= signExt;
                        offs_r        <= offs_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    addrError <= 1'b0;
                    if (bus.busAck) begin
                        state_r    <= ST_DONE;
                        bus.busReq <= 1'b0;
                        if (load_r) begin
                            readData <= format_load(size_r, sext_r, offs_r, bus.busRData);
                        end else begin
                            readData <= readData;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    addrError <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    addrError  <= 1'b0;
                    bus.busReq <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: hand-computed expected values for
// loads, stores, lane placement, width fallback, alignment handling and
// reset in the middle of a bus transaction.
`ifndef MEM_WORD
`define MEM_WORD 2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'b01
`endif
`ifndef MEM_BYTE
`define MEM_BYTE 2'b10
`endif

module tb_mem_access_unit;

    logic        clk;
    logic        rstN;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  mode;
    logic        signExt;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        addrError;

    mem_access_unit_if bus ();

    int n_checks;
    int n_fail;

    // results captured by do_access
    int          obs_stall_cnt;
    logic        obs_req;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd;
    logic        obs_we;
    logic [31:0] obs_rd;
    logic        obs_done_stall;
    logic        obs_err;

    mem_access_unit dut (
        .clk       (clk),
        .rstN      (rstN),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .mode      (mode),
        .signExt   (signExt),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .stall     (stall),
        .addrError (addrError),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transaction with busAck raised after wait_cycles REQ cycles.
    // Outputs are sampled on falling edges; the bus fields are captured in the
    // REQ cycle where busAck is high, readData in the following (DONE) cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] md,
                             input logic sx, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rdat,
                             input int wait_cycles);
        memRead = rd; memWrite = wr; mode = md; signExt = sx;
        addr = a; writeData = wd;
        bus.busRData = rdat; bus.busAck = 1'b0;
        obs_stall_cnt = 0; obs_err = 1'b0;
        @(negedge clk);
        if (stall) obs_stall_cnt++;
        obs_err = obs_err | addrError;
        @(posedge clk); #1;
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            if (stall) obs_stall_cnt++;
            obs_err = obs_err | addrError;
            @(posedge clk); #1;
        end
        bus.busAck = 1'b1;
        @(negedge clk);
        if (stall) obs_stall_cnt++;
        obs_err = obs_err | addrError;
        obs_req  = bus.busReq;
        obs_addr = bus.busAddr;
        obs_be   = bus.busByteEn;
        obs_wd   = bus.busWData;
        obs_we   = bus.busWe;
        @(posedge clk); #1;
        bus.busAck = 1'b0;
        memRead = 1'b0; memWrite = 1'b0;
        @(negedge clk);
        if (stall) obs_stall_cnt++;
        obs_err = obs_err | addrError;
        obs_done_stall = stall;
        obs_rd = readData;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; memRead = 1'b0; memWrite = 1'b0; mode = `MEM_WORD;
        signExt = 1'b0; addr = 32'h0; writeData = 32'h0;
        bus.busAck = 1'b0; bus.busRData = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busReq !== 1'b0) begin n_fail++; $display("FAIL reset_busReq: got %b, expected 0", bus.busReq); end
        n_checks++; if (bus.busWe !== 1'b0) begin n_fail++; $display("FAIL reset_busWe: got %b, expected 0", bus.busWe); end
        n_checks++; if (bus.busAddr !== 32'h0) begin n_fail++; $display("FAIL reset_busAddr: got %h, expected 0", bus.busAddr); end
        n_checks++; if (bus.busByteEn !== 4'h0) begin n_fail++; $display("FAIL reset_busByteEn: got %b, expected 0000", bus.busByteEn); end
        n_checks++; if (bus.busWData !== 32'h0) begin n_fail++; $display("FAIL reset_busWData: got %h, expected 0", bus.busWData); end
        n_checks++; if (readData !== 32'h0) begin n_fail++; $display("FAIL reset_readData: got %h, expected 0", readData); end
        n_checks++; if (addrError !== 1'b0) begin n_fail++; $display("FAIL reset_addrError: got %b, expected 0", addrError); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, expected 0", stall); end
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    task automatic test_load_word();
        do_access(1'b1, 1'b0, `MEM_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2);
        n_checks++; if (obs_stall_cnt !== 4) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d, expected 4", obs_stall_cnt); end
        n_checks++; if (obs_req !== 1'b1) begin n_fail++; $display("FAIL lw_busReq: got %b, expected 1", obs_req); end
        n_checks++; if (obs_addr !== 32'h10) begin n_fail++; $display("FAIL lw_busAddr: got %h, expected 00000010", obs_addr); end
        n_checks++; if (obs_be !== 4'b1111) begin n_fail++; $display("FAIL lw_byteEn: got %b, expected 1111", obs_be); end
        n_checks++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL lw_busWe: got %b, expected 0", obs_we); end
        n_checks++; if (obs_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_readData: got %h, expected deadbeef", obs_rd); end
        n_checks++; if (obs_done_stall !== 1'b0) begin n_fail++; $display("FAIL lw_done_stall: got %b, expected 0", obs_done_stall); end
        // busAck while idle must not start anything or disturb readData
        bus.busAck = 1'b1;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_ack_stall: got %b, expected 0", stall); end
        @(posedge clk); #1;
        bus.busAck = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busReq !== 1'b0) begin n_fail++; $display("FAIL idle_ack_busReq: got %b, expected 0", bus.busReq); end
        n_checks++; if (readData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_ack_readData: got %h, expected deadbeef", readData); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_subword();
        do_access(1'b1, 1'b0, `MEM_BYTE, 1'b1, 32'h13, 32'h0, 32'h80FF0000, 0);
        n_checks++; if (obs_stall_cnt !== 2) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d, expected 2", obs_stall_cnt); end
        n_checks++; if (obs_addr !== 32'h10) begin n_fail++; $display("FAIL lb_busAddr: got %h, expected 00000010", obs_addr); end
        n_checks++; if (obs_rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext: got %h, expected ffffff80", obs_rd); end
        do_access(1'b1, 1'b0, `MEM_BYTE, 1'b0, 32'h13, 32'h0, 32'h80FF0000, 0);
        n_checks++; if (obs_rd !== 32'h00000080) begin n_fail++; $display("FAIL lb_zext: got %h, expected 00000080", obs_rd); end
        do_access(1'b1, 1'b0, `MEM_HALF, 1'b0, 32'h10, 32'h0, 32'h12348001, 1);
        n_checks++; if (obs_rd !== 32'h00008001) begin n_fail++; $display("FAIL lh_zext_lo: got %h, expected 00008001", obs_rd); end
        do_access(1'b1, 1'b0, `MEM_HALF, 1'b1, 32'h12, 32'h0, 32'h80FF0000, 0);
        n_checks++; if (obs_rd !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_sext_hi: got %h, expected ffff80ff", obs_rd); end
    endtask

    task automatic test_store_half();
        do_access(1'b0, 1'b1, `MEM_HALF, 1'b0, 32'h22, 32'h1234ABCD, 32'h5A5A5A5A, 0);
        n_checks++; if (obs_addr !== 32'h20) begin n_fail++; $display("FAIL sh_busAddr: got %h, expected 00000020", obs_addr); end
        n_checks++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL sh_busWe: got %b, expected 1", obs_we); end
        n_checks++; if (obs_be !== 4'b1100) begin n_fail++; $display("FAIL sh_byteEn: got %b, expected 1100", obs_be); end
        n_checks++; if (obs_wd !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_busWData: got %h, expected abcdabcd", obs_wd); end
        n_checks++; if (obs_rd !== 32'hFFFF80FF) begin n_fail++; $display("FAIL sh_readData_hold: got %h, expected ffff80ff", obs_rd); end
    endtask

    task automatic test_store_byte();
        do_access(1'b0, 1'b1, `MEM_BYTE, 1'b0, 32'h05, 32'h000000AA, 32'h0, 0);
        n_checks++; if (obs_addr !== 32'h04) begin n_fail++; $display("FAIL sb_busAddr: got %h, expected 00000004", obs_addr); end
        n_checks++; if (obs_be !== 4'b0010) begin n_fail++; $display("FAIL sb_byteEn: got %b, expected 0010", obs_be); end
        n_checks++; if (obs_wd !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL sb_busWData: got %h, expected aaaaaaaa", obs_wd); end
        // read and write together: executed as a store, readData unchanged
        do_access(1'b1, 1'b1, `MEM_BYTE, 1'b1, 32'h07, 32'h00000055, 32'h12345678, 1);
        n_checks++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL rw_busWe: got %b, expected 1", obs_we); end
        n_checks++; if (obs_be !== 4'b1000) begin n_fail++; $display("FAIL rw_byteEn: got %b, expected 1000", obs_be); end
        n_checks++; if (obs_wd !== 32'h55555555) begin n_fail++; $display("FAIL rw_busWData: got %h, expected 55555555", obs_wd); end
        n_checks++; if (obs_rd !== 32'hFFFF80FF) begin n_fail++; $display("FAIL rw_readData_hold: got %h, expected ffff80ff", obs_rd); end
    endtask

    task automatic test_store_word_unknown_mode();
        do_access(1'b0, 1'b1, 2'b11, 1'b0, 32'h0C, 32'h11223344, 32'h0, 0);
        n_checks++; if (obs_addr !== 32'h0C) begin n_fail++; $display("FAIL sw_busAddr: got %h, expected 0000000c", obs_addr); end
        n_checks++; if (obs_be !== 4'b1111) begin n_fail++; $display("FAIL sw_byteEn: got %b, expected 1111", obs_be); end
        n_checks++; if (obs_wd !== 32'h11223344) begin n_fail++; $display("FAIL sw_busWData: got %h, expected 11223344", obs_wd); end
    endtask

    task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
        memRead = 1'b1; memWrite = 1'b0; mode = `MEM_WORD; signExt = 1'b0;
        addr = 32'h06; bus.busAck = 1'b0; bus.busRData = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b, expected 0", stall); end
        @(posedge clk); #1;
        memRead = 1'b0;
        @(negedge clk);
        n_checks++; if (addrError !== 1'b1) begin n_fail++; $display("FAIL mis_addrError_set: got %b, expected 1", addrError); end
        n_checks++; if (bus.busReq !== 1'b0) begin n_fail++; $display("FAIL mis_busReq: got %b, expected 0", bus.busReq); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (addrError !== 1'b0) begin n_fail++; $display("FAIL mis_addrError_clear: got %b, expected 0", addrError); end
        n_checks++; if (readData !== 32'hFFFF80FF) begin n_fail++; $display("FAIL mis_readData_hold: got %h, expected ffff80ff", readData); end
        @(posedge clk); #1;
`else
        do_access(1'b1, 1'b0, `MEM_WORD, 1'b0, 32'h06, 32'h0, 32'hCAFEF00D, 1);
        n_checks++; if (obs_addr !== 32'h04) begin n_fail++; $display("FAIL mis_busAddr: got %h, expected 00000004", obs_addr); end
        n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL mis_addrError: got %b, expected 0", obs_err); end
        n_checks++; if (obs_rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_readData: got %h, expected cafef00d", obs_rd); end
        do_access(1'b0, 1'b1, `MEM_HALF, 1'b0, 32'h23, 32'h0000BEEF, 32'h0, 0);
        n_checks++; if (obs_be !== 4'b1100) begin n_fail++; $display("FAIL mis_sh_byteEn: got %b, expected 1100", obs_be); end
        n_checks++; if (obs_wd !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL mis_sh_busWData: got %h, expected beefbeef", obs_wd); end
`endif
    endtask

    task automatic test_reset_mid_req();
        memRead = 1'b1; memWrite = 1'b0; mode = `MEM_WORD; signExt = 1'b0;
        addr = 32'h30; bus.busAck = 1'b0; bus.busRData = 32'h99999999;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.busReq !== 1'b1) begin n_fail++; $display("FAIL rst_req_busReq_before: got %b, expected 1", bus.busReq); end
        rstN = 1'b0; memRead = 1'b0;
        #1;
        n_checks++; if (bus.busReq !== 1'b0) begin n_fail++; $display("FAIL rst_req_busReq_async: got %b, expected 0", bus.busReq); end
        n_checks++; if (bus.busAddr !== 32'h0) begin n_fail++; $display("FAIL rst_req_busAddr: got %h, expected 0", bus.busAddr); end
        n_checks++; if (readData !== 32'h0) begin n_fail++; $display("FAIL rst_req_readData: got %h, expected 0", readData); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_req_stall: got %b, expected 0", stall); end
        @(posedge clk); #1;
        rstN = 1'b1; bus.busAck = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (bus.busReq !== 1'b0) begin n_fail++; $display("FAIL late_ack_busReq: got %b, expected 0", bus.busReq); end
            n_checks++; if (readData !== 32'h0) begin n_fail++; $display("FAIL late_ack_readData: got %h, expected 0", readData); end
            @(posedge clk); #1;
        end
        bus.busAck = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_word();
        test_load_subword();
        test_store_half();
        test_store_byte();
        test_store_word_unknown_mode();
        test_misaligned();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
